// File: rtl/dm_resp_pkg.sv
// Shared encodings for the data-memory responder: access sizes, direction and FSM states.
package dm_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Index of the final byte beat for a legal size (nbeats - 1).
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SZ_BYTE: last_beat = 2'd0;
      SZ_HALF: last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_array.sv
// Single-port byte storage: synchronous write, asynchronous read, never cleared.
module dm_byte_array #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] Mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      Mem[addr] <= wdata;
    end
  end

  assign rdata = Mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: one byte per cycle over a byte array,
// with a single-cycle extended response and a busy flag for pipeline stalls.
module data_mem_responder
  import dm_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  state_t              state, state_n;
  logic [1:0]          beat;
  logic                rw_q;
  logic [1:0]          size_q;
  logic                se_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   ext;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_rbyte;
  logic                mem_we;
  logic                accept;
  logic                last;

  assign accept   = (state == IDLE) && req_valid;
  assign last     = (beat == last_beat(size_q));
  assign mem_addr = addr_q + ADDR_W'(beat);
  assign mem_we   = (state == ACCESS) && (rw_q == RW_WRITE);

  dm_byte_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q[{beat, 3'b000} +: 8]),
    .rdata (mem_rbyte)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus outputs decoded purely from registered state.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_n = (req_size == SZ_ILL) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (last) begin
          state_n = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = (size_q == SZ_ILL);
        if ((size_q != SZ_ILL) && (rw_q == RW_READ)) begin
          resp_rdata = ext;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latches, beat counter and little-endian read assembly.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      beat    <= 2'd0;
      rw_q    <= RW_READ;
      size_q  <= SZ_BYTE;
      se_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      beat    <= 2'd0;
      rw_q    <= req_rw;
      size_q  <= req_size;
      se_q    <= req_se;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      if (rw_q == RW_READ) begin
        rdata_q[{beat, 3'b000} +: 8] <= mem_rbyte;
      end
      if (!last) begin
        beat <= beat + 2'd1;
      end
    end
  end

  always_comb begin
    ext = '0;
    case (size_q)
      SZ_BYTE: ext = {{(DATA_W-8){se_q & rdata_q[7]}}, rdata_q[7:0]};
      SZ_HALF: ext = {{(DATA_W-16){se_q & rdata_q[15]}}, rdata_q[15:0]};
      default: ext = rdata_q;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, extension, wrap, errors, stalls and reset.
module tb_data_mem_responder;

  logic        clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_size;
  logic        req_se;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_size   (req_size),
    .req_se     (req_se),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from IDLE; lat counts negedges after the accept edge until resp_valid (99 = timeout).
  task automatic issue(input logic rw, input logic [1:0] size, input logic se,
                       input logic [8:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_size  = size;
    req_se    = se;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = 99;
    rdata = 'x;
    err   = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat   = i;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic test_byte_writes();
    logic [7:0] vals [4];
    int lat; logic [31:0] rd; logic er;
    vals[0] = 8'h80; vals[1] = 8'h01; vals[2] = 8'hFF; vals[3] = 8'h7F;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 2'b00, 1'b0, 9'(i), {24'hABCDEF, vals[i]}, lat, rd, er);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_byte_lat[%0d] got=%0d exp=2", i, lat); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL wr_byte_resp[%0d] rdata=%h err=%b exp 0/0", i, rd, er); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dut.u_mem.Mem[i] !== vals[i]) begin errors++; $display("FAIL wr_byte_mem[%0d] got=%h exp=%h", i, dut.u_mem.Mem[i], vals[i]); end
    end
  endtask

  task automatic test_reads();
    int lat; logic [31:0] rd; logic er;
    issue(1'b0, 2'b10, 1'b0, 9'd0, 32'h0, lat, rd, er);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rd_word_lat got=%0d exp=5", lat); end
    checks++; if (rd !== 32'h7FFF0180) begin errors++; $display("FAIL rd_word got=%h exp=7fff0180", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_word_err got=%b exp=0", er); end
    issue(1'b0, 2'b00, 1'b1, 9'd0, 32'h0, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_byte_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL rd_byte_se got=%h exp=ffffff80", rd); end
    issue(1'b0, 2'b00, 1'b0, 9'd0, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL rd_byte_ze got=%h exp=00000080", rd); end
    issue(1'b0, 2'b00, 1'b1, 9'd3, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL rd_byte_se_pos got=%h exp=0000007f", rd); end
    issue(1'b0, 2'b01, 1'b1, 9'd2, 32'h0, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_half_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h00007FFF) begin errors++; $display("FAIL rd_half_se2 got=%h exp=00007fff", rd); end
    issue(1'b0, 2'b01, 1'b1, 9'd1, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFFF01) begin errors++; $display("FAIL rd_half_se1 got=%h exp=ffffff01", rd); end
    issue(1'b0, 2'b01, 1'b0, 9'd1, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000FF01) begin errors++; $display("FAIL rd_half_ze1 got=%h exp=0000ff01", rd); end
    issue(1'b0, 2'b10, 1'b1, 9'd0, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h7FFF0180) begin errors++; $display("FAIL rd_word_se got=%h exp=7fff0180", rd); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 1'b0, 9'd510, 32'hDEADBEEF, lat, rd, er);
    checks++; if (lat !== 5) begin errors++; $display("FAIL wrap_wr_lat got=%0d exp=5", lat); end
    checks++; if (dut.u_mem.Mem[510] !== 8'hEF) begin errors++; $display("FAIL wrap_mem510 got=%h exp=ef", dut.u_mem.Mem[510]); end
    checks++; if (dut.u_mem.Mem[511] !== 8'hBE) begin errors++; $display("FAIL wrap_mem511 got=%h exp=be", dut.u_mem.Mem[511]); end
    checks++; if (dut.u_mem.Mem[0] !== 8'hAD) begin errors++; $display("FAIL wrap_mem0 got=%h exp=ad", dut.u_mem.Mem[0]); end
    checks++; if (dut.u_mem.Mem[1] !== 8'hDE) begin errors++; $display("FAIL wrap_mem1 got=%h exp=de", dut.u_mem.Mem[1]); end
    issue(1'b0, 2'b10, 1'b0, 9'd510, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_rd got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 1'b0, 9'd4, 32'h44332211, lat, rd, er);
    issue(1'b1, 2'b11, 1'b0, 9'd4, 32'hFFFFFFFF, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ill_wr_lat got=%0d exp=1", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL ill_wr_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ill_wr_rdata got=%h exp=0", rd); end
    issue(1'b0, 2'b10, 1'b0, 9'd4, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL ill_mem_kept got=%h exp=44332211", rd); end
    issue(1'b0, 2'b11, 1'b1, 9'd4, 32'h0, lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ill_rd lat=%0d err=%b rdata=%h exp 1/1/0", lat, er, rd); end
  endtask

  task automatic test_back_to_back();
    int stall = 0;
    int pulses = 0;
    bit got2 = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_se = 1'b0;
    req_addr = 9'd16; req_wdata = 32'h01020304;
    @(posedge clk);
    #1 req_addr = 9'd20; req_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy && !req_ready) stall++;
      if (resp_valid) pulses++;
    end
    checks++; if (stall !== 5) begin errors++; $display("FAIL b2b_stall_cycles got=%0d exp=5", stall); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap ready=%b busy=%b exp 1/0", req_ready, busy); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin pulses++; got2 = 1; break; end
    end
    checks++; if (!got2 || pulses !== 2) begin errors++; $display("FAIL b2b_responses got=%0d exp=2", pulses); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_dup busy=%b exp=0", busy); end
    checks++; if ({dut.u_mem.Mem[19], dut.u_mem.Mem[18], dut.u_mem.Mem[17], dut.u_mem.Mem[16]} !== 32'h01020304)
      begin errors++; $display("FAIL b2b_first got=%h exp=01020304", {dut.u_mem.Mem[19], dut.u_mem.Mem[18], dut.u_mem.Mem[17], dut.u_mem.Mem[16]}); end
    checks++; if ({dut.u_mem.Mem[23], dut.u_mem.Mem[22], dut.u_mem.Mem[21], dut.u_mem.Mem[20]} !== 32'hA5A5A5A5)
      begin errors++; $display("FAIL b2b_second got=%h exp=a5a5a5a5", {dut.u_mem.Mem[23], dut.u_mem.Mem[22], dut.u_mem.Mem[21], dut.u_mem.Mem[20]}); end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [31:0] rd; logic er;
    int spurious = 0;
    issue(1'b1, 2'b10, 1'b0, 9'd8, 32'hCCBBAA55, lat, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_se = 1'b0;
    req_addr = 9'd8; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl ready=%b busy=%b exp 1/0", req_ready, busy); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0)
      begin errors++; $display("FAIL rst_mid_resp valid=%b err=%b rdata=%h exp 0/0/0", resp_valid, resp_err, resp_rdata); end
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid || busy) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL rst_mid_no_resp got=%0d exp=0", spurious); end
    checks++; if ({dut.u_mem.Mem[11], dut.u_mem.Mem[10], dut.u_mem.Mem[9], dut.u_mem.Mem[8]} !== 32'hCCBBAA44)
      begin errors++; $display("FAIL rst_mid_mem got=%h exp=ccbbaa44", {dut.u_mem.Mem[11], dut.u_mem.Mem[10], dut.u_mem.Mem[9], dut.u_mem.Mem[8]}); end
  endtask

  initial begin
    req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_se = 1'b0;
    req_addr = '0; req_wdata = '0; Reset = 1'b0;
    test_reset();
    test_byte_writes();
    test_reads();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
